// File: rtl/prefix_adder_pkg.sv
// Shared constants for the Kogge-Stone prefix adder.
// Width and prefix depth used by the adder top and its bench.
package prefix_adder_pkg;

    localparam int ADDER_WIDTH  = 32;
    localparam int ADDER_LEVELS = $clog2(ADDER_WIDTH);

endpackage

// File: rtl/prefix_adder_32_pg_black_cell.sv
// Kogge-Stone black cell: merges a high and a low
// generate/propagate group into one wider group.
module pg_black_cell (
    input  logic gh,
    input  logic ph,
    input  logic gl,
    input  logic pl,
    output logic g,
    output logic p
);

    assign g = gh | (ph & gl);
    assign p = ph & pl;

endmodule

// File: rtl/prefix_adder_32.sv
// 32-bit Kogge-Stone adder with carry-in and a
// registered sum/carry-out (one-cycle latency).
module prefix_adder_32
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int HALF   = WIDTH / 2;

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gc;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] s;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Levels 0..LEVELS-1 keep both G and P; level 0 folds cin into bit 0.
    for (genvar k = 0; k < LEVELS; k++) begin : lvl
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        if (k == 0) begin : pre
            assign g[0] = gen[0] | (prop[0] & cin);
            if (WIDTH > 1) begin : hi
                assign g[WIDTH-1:1] = gen[WIDTH-1:1];
            end
            assign p = {prop[WIDTH-1:1], 1'b0};
        end else begin : tree
            localparam int D = 1 << (k - 1);
            for (genvar i = 0; i < WIDTH; i++) begin : node
                if (i >= D) begin : blk
                    pg_black_cell u_cell (
                        .gh (lvl[k-1].g[i]),
                        .ph (lvl[k-1].p[i]),
                        .gl (lvl[k-1].g[i-D]),
                        .pl (lvl[k-1].p[i-D]),
                        .g  (g[i]),
                        .p  (p[i])
                    );
                end else begin : buf_n
                    assign g[i] = lvl[k-1].g[i];
                    assign p[i] = lvl[k-1].p[i];
                end
            end
        end
    end

    // Final level only needs group generate: every G is now a bit carry.
    for (genvar i = 0; i < WIDTH; i++) begin : fin
        if (i >= HALF) begin : gray
            assign gc[i] = lvl[LEVELS-1].g[i]
                         | (lvl[LEVELS-1].p[i] & lvl[LEVELS-1].g[i-HALF]);
        end else begin : buf_n
            assign gc[i] = lvl[LEVELS-1].g[i];
        end
    end

    assign carry = {gc[WIDTH-2:0], cin};
    assign s     = prop ^ carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= s;
            cout <= gc[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_prefix_adder_32.sv
// Self-checking bench for prefix_adder_32: directed corners,
// async reset, and back-to-back random vectors vs a+b+cin.
module tb_prefix_adder_32;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;

    int tests = 0;
    int fails = 0;

    prefix_adder_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] s_exp,
                         input logic c_exp);
        tests++;
        assert (sum === s_exp && cout === c_exp)
        else begin
            fails++;
            $error("FAIL %s: got sum=%h cout=%b, expected sum=%h cout=%b",
                   tag, sum, cout, s_exp, c_exp);
        end
    endtask

    // Drive one vector, clock it in, compare against the 33-bit golden sum.
    task automatic add_step(input string tag,
                            input logic [31:0] va,
                            input logic [31:0] vb,
                            input logic vc);
        logic [32:0] golden;
        a   = va;
        b   = vb;
        cin = vc;
        golden = {1'b0, va} + {1'b0, vb} + {32'd0, vc};
        @(posedge clk);
        #1;
        check(tag, golden[31:0], golden[32]);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;

        rst_n = 1'b0;
        a     = 32'h1234_5678;
        b     = 32'h9ABC_DEF0;
        cin   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 32'h0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        add_step("first_after_release", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

        add_step("one_plus_one", 32'h0000_0001, 32'h0000_0001, 1'b0);
        add_step("full_carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        add_step("cin_only", 32'h0000_0001, 32'h0000_0001, 1'b1);
        add_step("all_prop_nc", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        add_step("all_prop_c", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        add_step("max_max_c", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        add_step("zero_zero", 32'h0, 32'h0, 1'b0);
        add_step("zero_cin", 32'h0, 32'h0, 1'b1);
        add_step("alt_bits", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);

        // Async assertion mid-cycle must clear with no clock edge.
        add_step("pre_async", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_clear", 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_edge_low", 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        add_step("post_async", 32'hFFFF_0000, 32'h0001_0000, 1'b0);

        for (int n = 0; n < 300; n++) begin
            ra = $urandom;
            rc = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       rb = ~ra;
                1:       rb = 32'hFFFF_FFFF - ra + 32'd1;
                default: rb = $urandom;
            endcase
            add_step("random", ra, rb, rc);
        end

        add_step("max_max_c_end", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prefix_adder_32.md
Name: prefix_adder_32

Overview:
- 32-bit two-operand binary adder with carry-in, built on a parallel-prefix (Kogge-Stone) carry network.
- Produces a 32-bit sum and a carry-out.
- Inputs are sampled and the result is registered on the clock, giving a fixed one-cycle latency.
- Used as a pipeline-friendly arithmetic leaf wherever a fast wide add is needed.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a power of two ≥ 2; prefix depth = log2(WIDTH) (5 levels at default).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry into bit 0
- sum  output  WIDTH  registered (a + b + cin) mod 2^WIDTH
- cout  output  1  registered carry out of bit WIDTH-1

Interface (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset:
  - rst_n low immediately clears sum and cout to 0, independent of clk.
  - Outputs stay 0 while rst_n is low.
  - Release is synchronous in effect: the first capture happens on the first rising clk edge with rst_n high.
- Pre-processing (combinational), per bit i:
  - g[i] = a[i] & b[i]
  - p[i] = a[i] ^ b[i]
  - cin is folded in as the bit -1 generate: G[-1] = cin, P[-1] = 0. Equivalently, bit 0 uses g0' = g[0] | (p[0] & cin).
- Prefix tree (combinational):
  - Kogge-Stone, log2(WIDTH) levels.
  - At level k (distance d = 2^k), node i with i ≥ d: G = Gh | (Ph & Gl), P = Ph & Pl, where h is (i, level k-1) and l is (i-d, level k-1).
  - Nodes with i < d pass through unchanged.
  - After the final level, G[i] is the carry out of bit i, including cin.
- Post-processing:
  - carry into bit 0 = cin
  - carry into bit i (i > 0) = G[i-1]
  - s[i] = p[i] ^ carry_in[i]
  - cout = G[WIDTH-1]
- Registering: s and cout are captured into the sum/cout flops on each rising clk edge. There is no enable, so a new result is available every cycle (throughput 1/cycle).
- Latency: the result for inputs stable before edge N appears on the outputs after edge N and holds until edge N+1.
- Arithmetic rule: {cout, sum} == a + b + cin, exactly (WIDTH+1)-bit unsigned.
- No overflow flag is generated. Signed overflow is the caller's responsibility.
- Boundaries:
  - All-ones + 1 wraps sum to 0 with cout = 1.
  - All-ones + all-ones + 1 gives sum all-ones, cout = 1.
  - A long propagate chain (p all ones) resolves entirely through the tree, with no ripple path.
- Reset asserted mid-operation discards any pending result; outputs read 0 until the first edge after release.
- No latches. Every combinational net is fully assigned.

Decomposition:
- Shared package prefix_adder_pkg:
  - constant ADDER_WIDTH = 32
  - derived constant ADDER_LEVELS = 5
  - function clog2 if the toolchain lacks $clog2
- Sub-module pg_black_cell:
  - inputs Gh, Ph, Gl, Pl; outputs G = Gh | (Ph & Gl), P = Ph & Pl.
  - Instantiated in a generate grid (level × bit).
  - Pass-through (buffer) positions are plain assigns.
- The top holds pre-processing, the generate tree, post-XOR, and the output registers.

Test Plan:
- Reset: hold rst_n=0 with nonzero a/b, toggle clk -> sum=00000000, cout=0. Assert rst_n asynchronously mid-cycle -> outputs clear without a clock edge.
- a=00000001, b=00000001, cin=0, one clk -> sum=00000002, cout=0.
- a=FFFFFFFF, b=00000001, cin=0 -> sum=00000000, cout=1 (full carry propagation).
- a=00000001, b=00000001, cin=1 -> sum=00000003, cout=0.
- a=80000000, b=7FFFFFFF, cin=0 -> sum=FFFFFFFF, cout=0 (all-propagate, no carry). Same operands with cin=1 -> sum=00000000, cout=1.
- Back-to-back random vectors, one per cycle, including FFFFFFFF+FFFFFFFF+1 -> sum=FFFFFFFF, cout=1. Each output is compared one cycle later against the 33-bit golden a+b+cin.
